// File: rtl/t_counter_n.sv
// N-stage T flip-flop counter with enable, up/down, modulus, parallel load,
// terminal count, one-cycle wrap pulse and sticky overflow.
module t_counter_n #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             at_max;
  logic             at_zero;
  logic             din_ok;

  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);
  assign din_ok  = (32'(din) < 32'(MOD));

  // General-modulus next value; t falls out as the bits that must flip.
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = din_ok ? din : MAX_VAL;
    end else if (en) begin
      if (up) begin
        nxt = at_max ? '0 : q + 1'b1;
      end else begin
        nxt = at_zero ? MAX_VAL : q - 1'b1;
      end
    end
  end

  assign t = q ^ nxt;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q <= RST_VAL;
    end else begin
      q <= q ^ t;
    end
  end

  assign nq = ~q;
  assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

  // Set beats clear when a wrap and clr_ovf land on the same edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= tc;
      if (tc) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
